// File: rtl/fc_result_writer_pkg.sv
// Shared FC-layer constants: default widths and counts, writer FSM state encoding,
// and the signed output saturation limits.
package fc_result_writer_pkg;

    localparam int DEF_DATA_WIDTH_FC           = 16;
    localparam int DEF_ACCUM_DATA_WIDTH_FC     = 32;
    localparam int DEF_PO                      = 2;
    localparam int DEF_OUTNEURON               = 10;
    localparam int DEF_FC_OUTNEURON_ADDR_WIDTH = 4;
    localparam int DEF_FRAC_SHIFT              = 12;

    localparam int SAT_MAX_FC = (1 << (DEF_DATA_WIDTH_FC - 1)) - 1;
    localparam int SAT_MIN_FC = -(1 << (DEF_DATA_WIDTH_FC - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fc_state_t;

endpackage

// File: rtl/fc_result_writer_quant_lane.sv
// One-lane quantiser (fc_quant_lane): round-half-up, arithmetic shift, signed saturate.
// Build option FC_WRITE_RELU_EN zeroes negative results after saturation.
module fc_result_writer_quant_lane #(
    parameter int DATA_WIDTH_FC       = 16,
    parameter int ACCUM_DATA_WIDTH_FC = 32,
    parameter int FRAC_SHIFT          = 12
) (
    input  logic signed [ACCUM_DATA_WIDTH_FC-1:0] x,
    output logic        [DATA_WIDTH_FC-1:0]       q,
    output logic                                  sat
);
    localparam int AW = ACCUM_DATA_WIDTH_FC;

    // One guard bit above the accumulator keeps the rounding add from wrapping.
    localparam logic signed [AW:0] HALF  = {{AW{1'b0}}, 1'b1} <<< (FRAC_SHIFT - 1);
    localparam logic signed [AW:0] MAX_V = ({{AW{1'b0}}, 1'b1} <<< (DATA_WIDTH_FC - 1)) - {{AW{1'b0}}, 1'b1};
    localparam logic signed [AW:0] MIN_V = ~MAX_V;

    logic signed [AW:0]            sum;
    logic signed [AW:0]            t;
    logic                          sat_hi;
    logic                          sat_lo;
    logic        [DATA_WIDTH_FC-1:0] q_sat;

    always_comb begin
        sum    = $signed({x[AW-1], x}) + HALF;
        t      = sum >>> FRAC_SHIFT;
        sat_hi = (t > MAX_V);
        sat_lo = (t < MIN_V);
        sat    = sat_hi || sat_lo;
        if (sat_hi) begin
            q_sat = MAX_V[DATA_WIDTH_FC-1:0];
        end else if (sat_lo) begin
            q_sat = MIN_V[DATA_WIDTH_FC-1:0];
        end else begin
            q_sat = t[DATA_WIDTH_FC-1:0];
        end
`ifdef FC_WRITE_RELU_EN
        q = q_sat[DATA_WIDTH_FC-1] ? '0 : q_sat;
`else
        q = q_sat;
`endif
    end

endmodule

// File: rtl/fc_result_writer.sv
// FC-layer writeback: quantises PO accumulator lanes per beat and writes them as one word
// to the out-neuron RAM with back-pressure. Build option: FC_WRITE_RELU_EN (ReLU on lanes).
module fc_result_writer
    import fc_result_writer_pkg::*;
#(
    parameter int DATA_WIDTH_FC           = DEF_DATA_WIDTH_FC,
    parameter int ACCUM_DATA_WIDTH_FC     = DEF_ACCUM_DATA_WIDTH_FC,
    parameter int PO                      = DEF_PO,
    parameter int OUTNEURON               = DEF_OUTNEURON,
    parameter int FC_OUTNEURON_ADDR_WIDTH = DEF_FC_OUTNEURON_ADDR_WIDTH,
    parameter int FRAC_SHIFT              = DEF_FRAC_SHIFT
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                result_valid,
    output logic                                result_ready,
    input  logic [PO*ACCUM_DATA_WIDTH_FC-1:0]   result,
    input  logic                                mem_ready,
    output logic                                fc_outneuron_wren_a,
    output logic [FC_OUTNEURON_ADDR_WIDTH-1:0]  address,
    output logic [PO*DATA_WIDTH_FC-1:0]         dataout,
    output logic                                layer_done,
    output logic [15:0]                         sat_count
);
    localparam int AW    = FC_OUTNEURON_ADDR_WIDTH;
    localparam int BEATS = OUTNEURON / PO;

    localparam logic [AW-1:0] LAST_ADDR = AW'(BEATS - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW:0]   BEATS_C   = (AW + 1)'(BEATS);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

    fc_state_t state, state_next;

    logic [PO*DATA_WIDTH_FC-1:0] quant;
    logic [PO*DATA_WIDTH_FC-1:0] s1_data;
    logic [PO*DATA_WIDTH_FC-1:0] s2_data;
    logic [PO-1:0]               lane_sat;
    logic                        s1_valid;
    logic                        s2_valid;
    logic                        s1_advance;
    logic                        accept;
    logic                        last_write;
    logic [AW:0]                 in_count;
    logic [15:0]                 sat_beat;
    logic [16:0]                 sat_sum;

    for (genvar i = 0; i < PO; i++) begin : g_lane
        fc_result_writer_quant_lane #(
            .DATA_WIDTH_FC      (DATA_WIDTH_FC),
            .ACCUM_DATA_WIDTH_FC(ACCUM_DATA_WIDTH_FC),
            .FRAC_SHIFT         (FRAC_SHIFT)
        ) u_lane (
            .x  (result[i*ACCUM_DATA_WIDTH_FC +: ACCUM_DATA_WIDTH_FC]),
            .q  (quant[i*DATA_WIDTH_FC +: DATA_WIDTH_FC]),
            .sat(lane_sat[i])
        );
    end

    // The beat count cap keeps surplus beats out while the last words drain.
    assign fc_outneuron_wren_a = s2_valid && mem_ready;
    assign s1_advance          = !s2_valid || fc_outneuron_wren_a;
    assign result_ready        = (state == RUN) && (in_count < BEATS_C) && (!s1_valid || s1_advance);
    assign accept              = result_valid && result_ready;
    assign last_write          = fc_outneuron_wren_a && (address == LAST_ADDR);
    assign dataout             = s2_data;
    assign layer_done          = (state == DONE);

    always_comb begin
        sat_beat = '0;
        for (int i = 0; i < PO; i++) begin
            sat_beat = sat_beat + 16'(lane_sat[i]);
        end
        sat_sum = {1'b0, sat_count} + {1'b0, sat_beat};
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_write) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_data   <= '0;
            s2_data   <= '0;
            address   <= '0;
            sat_count <= '0;
            in_count  <= '0;
        end else begin
            state <= state_next;

            if (state == IDLE && start) begin
                address   <= '0;
                sat_count <= '0;
                in_count  <= '0;
            end else begin
                if (accept) begin
                    in_count  <= in_count + CNT_ONE;
                    sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
                end
                if (fc_outneuron_wren_a) begin
                    address <= (address == LAST_ADDR) ? '0 : address + ADDR_ONE;
                end
            end

            // S2 only reloads when it is empty or its word is leaving this cycle.
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= quant;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end

            if (s1_advance) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end
    end

endmodule
